// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_master
//  Purpose  : Clause-22 MDIO management master. Serialises one read or write
//             frame per request onto MDC/MDIO (split out/oe/in) and returns
//             read data plus a turnaround-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module mdio_master #(
  parameter int CLK_DIV      = 4,   // MDC half-period in i_Clk cycles (>= 2)
  parameter int PREAMBLE_LEN = 32   // preamble '1' bits (0..32)
) (
  input  logic        i_Clk,
  input  logic        w_ARstLogic_L,
  input  logic        i_Start,
  input  logic        i_WEn,
  input  logic [4:0]  i5_PhyAddr,
  input  logic [4:0]  i5_RegAddr,
  input  logic [15:0] i16_WrData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [15:0] o16_RdData,
  output logic        o_RdError,
  output logic        o_Mdc,
  output logic        o_MdioOut,
  output logic        o_MdioOe,
  input  logic        i_MdioIn
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] c_DIV_PEN  = DIV_W'(CLK_DIV - 2);
  localparam logic [5:0]       c_PRE_LAST = 6'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic             mdc_q, mdc_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             wen_q, wen_d;
  logic [31:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic             taerr_q, taerr_d;
  logic [15:0]      rd_q, rd_d;
  logic             rderr_q, rderr_d;

  logic             w_div_end;
  logic             w_sect_last;
  state_t           w_sect_next;

  assign w_div_end  = (div_q == c_DIV_LAST);
  assign o_Busy     = (state_q != S_IDLE);
  assign o_Done     = done_q;
  assign o16_RdData = rd_q;
  assign o_RdError  = rderr_q;
  assign o_Mdc      = mdc_q;
  assign o_MdioOut  = out_q;
  assign o_MdioOe   = oe_q;

  // Last bit of the current frame section and the section that follows it
  always_comb begin
    w_sect_last = 1'b0;
    w_sect_next = state_q;
    case (state_q)
      S_PRE: begin w_sect_last = (bit_q == c_PRE_LAST); w_sect_next = S_HDR;  end
      S_HDR: begin w_sect_last = (bit_q == 6'd13);      w_sect_next = S_TA;   end
      S_TA:  begin w_sect_last = (bit_q == 6'd1);       w_sect_next = S_DATA; end
      default: ;
    endcase
  end

  // Frame sequencing: accept, MDC phase timing, bit shifting and completion
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mdc_d   = mdc_q;
    out_d   = out_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    wen_d   = wen_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    taerr_d = taerr_q;
    rd_d    = rd_q;
    rderr_d = rderr_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          wen_d   = i_WEn;
          // ST, OP, PHYAD, REGAD, TA, DATA; read TA/DATA slots are never driven
          tx_d    = {2'b01, (i_WEn ? 2'b01 : 2'b10), i5_PhyAddr, i5_RegAddr,
                     (i_WEn ? 2'b10 : 2'b11), (i_WEn ? i16_WrData : 16'hFFFF)};
          div_d   = '0;
          bit_d   = '0;
          mdc_d   = 1'b0;
          oe_d    = 1'b1;
          taerr_d = 1'b0;
          if (PREAMBLE_LEN == 0) begin
            state_d = S_HDR;
            out_d   = 1'b0;   // first ST bit
          end else begin
            state_d = S_PRE;
            out_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        mdc_d   = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b1;
        div_d   = '0;
        if (wen_q) begin
          rderr_d = 1'b0;
        end else begin
          rd_d    = rx_q;
          rderr_d = taerr_q;
        end
      end
      default: begin
        div_d = w_div_end ? '0 : div_q + DIV_W'(1);
        if (!mdc_q) begin
          if (w_div_end) begin
            mdc_d = 1'b1;
            if (state_q == S_TA && bit_q == 6'd1) taerr_d = i_MdioIn;
            if (state_q == S_DATA) rx_d = {rx_q[14:0], i_MdioIn};
          end
        end else if (state_q == S_DATA && bit_q == 6'd15 && div_q == c_DIV_PEN) begin
          // DONE occupies the final high cycle of the last bit
          state_d = S_DONE;
        end else if (w_div_end) begin
          mdc_d = 1'b0;
          bit_d = w_sect_last ? '0 : bit_q + 6'd1;
          if (w_sect_last) state_d = w_sect_next;
          if (state_q == S_PRE) begin
            out_d = w_sect_last ? tx_q[31] : 1'b1;
          end else begin
            out_d = tx_q[30];
            tx_d  = {tx_q[30:0], 1'b0};
          end
          oe_d = wen_q || (state_d == S_PRE) || (state_d == S_HDR);
        end
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
    if (!w_ARstLogic_L) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      mdc_q   <= 1'b0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      taerr_q <= 1'b0;
      rd_q    <= '0;
      rderr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mdc_q   <= mdc_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      taerr_q <= taerr_d;
      rd_q    <= rd_d;
      rderr_q <= rderr_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO management master: serialises one read or write frame per request onto MDC/MDIO and returns read data and a status flag.
- Drives the PHY-side management interface whose slave end is the SGMII register block's io_Mdio/i_Mdc pins. Used for configuring external PHYs and for loop-testing the SGMII register block.
- Tristate is split into out/oe/in; the top level builds the pad.

Parameters:
- CLK_DIV, 4, MDC half-period in i_Clk cycles; minimum 2.
- PREAMBLE_LEN, 32, number of preamble '1' bits; range 0..32.

Ports:
- i_Clk  in  1  system clock
- w_ARstLogic_L  in  1  reset, asynchronous, active-low
- i_Start  in  1  request strobe; accepted only when o_Busy=0
- i_WEn  in  1  1=write frame, 0=read frame; latched at accept
- i5_PhyAddr  in  5  PHY address; latched at accept
- i5_RegAddr  in  5  register address; latched at accept
- i16_WrData  in  16  write data; latched at accept
- o_Busy  out  1  frame in progress
- o_Done  out  1  one-cycle pulse at frame end
- o16_RdData  out  16  last read data
- o_RdError  out  1  read turnaround error on the last frame
- o_Mdc  out  1  management clock
- o_MdioOut  out  1  MDIO drive value
- o_MdioOe  out  1  MDIO output enable
- i_MdioIn  in  1  MDIO pad input, already synchronised by the top level

Behaviour:
- Reset values: o_Mdc=0, o_MdioOut=1, o_MdioOe=0, o_Busy=0, o_Done=0, o16_RdData=0, o_RdError=0, FSM=IDLE.
- Reset mid-frame returns all outputs to these values immediately. The partial frame is abandoned and no o_Done is generated.
- Accept:
  - i_Start with o_Busy=0 at clock edge N latches all request inputs.
  - o_Busy=1 from N+1.
  - i_Start while o_Busy=1 is ignored; no queueing.
- Bit timing:
  - Each bit lasts 2*CLK_DIV cycles: MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - o_MdioOut/o_MdioOe change only at the start of a low phase.
  - i_MdioIn is sampled on the i_Clk edge at which o_Mdc goes 0->1.
  - The first bit's low phase starts at N+1.
- Frame, MSB first, total F = PREAMBLE_LEN+32 bits:
  - PRE: PREAMBLE_LEN x '1'.
  - ST: 01.
  - OP: 01 for write, 10 for read.
  - PHYAD: 5 bits.
  - REGAD: 5 bits.
  - TA: 2 bits.
  - DATA: 16 bits.
- FSM: IDLE -> PRE (skipped if PREAMBLE_LEN=0) -> HDR (14 bits: ST, OP, PHYAD, REGAD) -> TA -> DATA -> DONE -> IDLE.
  - A 6-bit bit counter selects transitions.
  - A divider counter of width clog2(CLK_DIV) times the phases.
- Write frame: o_MdioOe=1 for all F bits; TA driven as "10"; DATA = latched i16_WrData.
- Read frame:
  - o_MdioOe=1 through REGAD, then 0 for TA and DATA.
  - The second TA bit is sampled; a value of 1 sets the error flag.
  - 16 DATA bits are shifted into an internal register, MSB first.
- Completion:
  - The last bit's high phase ends at cycle N+2*CLK_DIV*F. In that cycle the FSM enters DONE; o_Busy=1, o_Mdc=1.
  - At N+2*CLK_DIV*F+1: o_Done=1 for exactly one cycle, o_Busy=0, o_Mdc=0, o_MdioOe=0, o_MdioOut=1.
  - On read: o16_RdData is loaded with the shifted value and o_RdError with the TA flag, both at the same edge as o_Done rises.
  - On write: o16_RdData is held unchanged and o_RdError is cleared to 0.
- Back-to-back: i_Start during the o_Done cycle is accepted (o_Busy=0). The next frame begins the following cycle with no idle bit.
- o_Mdc is held low whenever IDLE, i.e. no free-running clock.

Test Plan:
- Write, CLK_DIV=4, PHY=0x01, REG=0x00, data 0x1140, i_Start at N -> 64 bits on o_MdioOut sampled at MDC rises = 32x'1', 0101 00001 00000 10 0001000101000000; o_MdioOe=1 throughout; o_Done at N+513; o_RdError=0.
- Read, PHY=0x02, REG=0x05, bench model drives TA2=0 and data 0x796D -> o_MdioOe=0 from TA bit 1 onward; OP bits 10; o16_RdData=0x796D and o_RdError=0 at o_Done.
- Read with no PHY (i_MdioIn held 1) -> o16_RdData=0xFFFF, o_RdError=1. A subsequent write frame clears o_RdError to 0.
- i_Start pulsed mid-frame with different addresses -> ignored; current frame bits unchanged; exactly one o_Done.
- i_Start asserted in the o_Done cycle -> o_Busy=1 next cycle; second frame's first preamble low phase starts immediately. With PREAMBLE_LEN=0, the frame is 32 bits and o_Done is at N+257.
- Assert w_ARstLogic_L=0 during DATA of a read -> o_Mdc=0, o_MdioOe=0, o_Busy=0, o16_RdData=0 immediately; no o_Done after release; a new request then completes normally.
